// File: rtl/ps2_host_tx_pkg.sv
// ps2_host_tx_pkg
//   Shared definitions for the PS/2 host-to-device transmitter.
//   Contents: FSM state encoding, frame constants, keyboard command and
//   response codes, and the odd-parity helper.
package ps2_host_tx_pkg;

   typedef logic [7:0] ps2_byte_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INHIBIT,
      ST_RTS,
      ST_DATA,
      ST_PARITY,
      ST_ACK,
      ST_LINEWAIT,
      ST_DONE
   } ps2_state_e;

   // Device falling edges: 1..8 data, 9 parity, 10 stop, 11 ACK.
   localparam int unsigned DATA_BITS   = 8;
   localparam int unsigned EDGE_PARITY = 9;
   localparam int unsigned EDGE_STOP   = 10;
   localparam int unsigned EDGE_ACK    = 11;

   // Host-to-keyboard commands.
   localparam ps2_byte_t CMD_SET_LEDS = 8'hED;
   localparam ps2_byte_t CMD_RESET    = 8'hFF;
   localparam ps2_byte_t CMD_ECHO     = 8'hEE;

   // Keyboard responses, seen by the separate receive path.
   localparam ps2_byte_t RSP_ACK      = 8'hFA;
   localparam ps2_byte_t RSP_RESEND   = 8'hFE;

   // Parity bit that makes the 9-bit data+parity field odd.
   function automatic logic odd_parity(input ps2_byte_t b);
      return ~^b;
   endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if
//   Command/status handshake between a requester and ps2_host_tx.
//   tx_data/tx_valid : command byte and request (requester -> block)
//   tx_ready         : block idle, will accept tx_valid
//   busy             : transfer in progress
//   done             : one-cycle end-of-transfer pulse
//   ack_ok/err_nack/err_timeout : outcome, valid with done
//   Modports: master = requester, slave = transmitter.
interface ps2_host_tx_if;
   import ps2_host_tx_pkg::*;

   ps2_byte_t tx_data;
   logic      tx_valid;
   logic      tx_ready;
   logic      busy;
   logic      done;
   logic      ack_ok;
   logic      err_nack;
   logic      err_timeout;

   modport master (
      output tx_data, tx_valid,
      input  tx_ready, busy, done, ack_ok, err_nack, err_timeout
   );

   modport slave (
      input  tx_data, tx_valid,
      output tx_ready, busy, done, ack_ok, err_nack, err_timeout
   );

endinterface

// File: rtl/ps2_line_filter.sv
// ps2_line_filter
//   Two-flop synchronizer followed by a debounce filter for one open-drain
//   PS/2 line. The filtered output only changes after FILTER_LEN consecutive
//   synchronized samples disagree with it. Resets to 1 (released line).
//   Ports: clk, rst_n (async, active low), line_in (raw pin),
//          line_f (filtered level).
module ps2_line_filter #(
   parameter int unsigned FILTER_LEN = 20
) (
   input  logic clk,
   input  logic rst_n,
   input  logic line_in,
   output logic line_f
);

   localparam int unsigned CW = $clog2(FILTER_LEN + 1);

   logic [1:0]    sync;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync   <= 2'b11;
         cnt    <= '0;
         line_f <= 1'b1;
      end else begin
         sync <= {sync[0], line_in};
         if (sync[1] == line_f) begin
            cnt <= '0;
         end else if (cnt == CW'(FILTER_LEN - 1)) begin
            // FILTER_LEN-th disagreeing sample in a row: accept new level
            line_f <= sync[1];
            cnt    <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx
//   PS/2 host-to-device transmitter. Sends one command byte to the keyboard
//   over the shared open-drain PS2_CLK/PS2_DATA lines: inhibit, request to
//   send, clock out start/data/parity/stop on device falling edges, then
//   check the device ACK. Lines are only ever pulled low through *_oe.
//   Ports:
//     clk, rst_n           system clock, async active-low reset
//     tx (slave modport)   command handshake and transfer status
//     ps2_clk_in/data_in   raw pin levels
//     ps2_clk_oe/data_oe   1 = pull line low, 0 = release
//   Build option: define PS2_TX_RETRY_EN to retry a NACKed or timed-out
//   transfer up to MAX_RETRY extra times with the same byte; only the final
//   attempt reports done/err_*. Without it every failure ends the transfer.
module ps2_host_tx
   import ps2_host_tx_pkg::*;
#(
   parameter int unsigned INHIBIT_CYCLES = 12000,
   parameter int unsigned TIMEOUT_CYCLES = 1500000,
   parameter int unsigned FILTER_LEN     = 20,
   parameter int unsigned MAX_RETRY      = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   ps2_host_tx_if.slave tx,
   input  logic         ps2_clk_in,
   input  logic         ps2_data_in,
   output logic         ps2_clk_oe,
   output logic         ps2_data_oe
);

`ifdef PS2_TX_RETRY_EN
   localparam bit RETRY_EN = 1'b1;
`else
   localparam bit RETRY_EN = 1'b0;
`endif

   localparam int          RETRY_LIMIT = RETRY_EN ? int'(MAX_RETRY) : 0;
   localparam int unsigned RW = $clog2(MAX_RETRY + 2);
   localparam int unsigned IW = $clog2(INHIBIT_CYCLES);
   localparam int unsigned WW = $clog2(TIMEOUT_CYCLES);

   ps2_state_e    state;
   ps2_byte_t     byte_q;
   logic          par_q;
   logic [3:0]    bit_idx;
   logic          ack_r;
   logic [IW-1:0] inh_cnt;
   logic [WW-1:0] wdog;
   logic [RW-1:0] retry_cnt;

   logic clk_f, data_f, clk_f_q;
   logic fall, line_idle;
   logic wd_armed, wd_hit, nack_end, can_retry, restart;

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
      .clk     (clk),
      .rst_n   (rst_n),
      .line_in (ps2_clk_in),
      .line_f  (clk_f)
   );

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
      .clk     (clk),
      .rst_n   (rst_n),
      .line_in (ps2_data_in),
      .line_f  (data_f)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) clk_f_q <= 1'b1;
      else        clk_f_q <= clk_f;
   end

   // Device falling edge, visible the cycle after the filter output drops.
   assign fall      = clk_f_q & ~clk_f;
   assign line_idle = clk_f & data_f;

   // Watchdog runs from RTS until the lines go idle after the ACK.
   assign wd_armed  = state inside {ST_RTS, ST_DATA, ST_PARITY, ST_ACK, ST_LINEWAIT};
   assign wd_hit    = wd_armed && !fall && (wdog == WW'(TIMEOUT_CYCLES - 1));
   assign nack_end  = (state == ST_LINEWAIT) && line_idle && !ack_r && !wd_hit;
   assign can_retry = int'(retry_cnt) < RETRY_LIMIT;
   assign restart   = (wd_hit | nack_end) & can_retry;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wdog <= '0;
      end else if (!wd_armed || fall || wd_hit) begin
         wdog <= '0;
      end else begin
         wdog <= wdog + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retry_cnt <= '0;
      end else if (state == ST_IDLE) begin
         retry_cnt <= '0;
      end else if (restart) begin
         retry_cnt <= retry_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= ST_IDLE;
         byte_q         <= '0;
         par_q          <= 1'b0;
         bit_idx        <= '0;
         ack_r          <= 1'b0;
         inh_cnt        <= '0;
         ps2_clk_oe     <= 1'b0;
         ps2_data_oe    <= 1'b0;
         tx.tx_ready    <= 1'b1;
         tx.busy        <= 1'b0;
         tx.done        <= 1'b0;
         tx.ack_ok      <= 1'b0;
         tx.err_nack    <= 1'b0;
         tx.err_timeout <= 1'b0;
      end else begin
         // Status strobes are single-cycle; only the entry into DONE sets them.
         tx.done        <= 1'b0;
         tx.ack_ok      <= 1'b0;
         tx.err_nack    <= 1'b0;
         tx.err_timeout <= 1'b0;

         if (wd_hit) begin
            // Device went quiet: let go of both lines, then retry or report.
            ps2_data_oe <= 1'b0;
            ps2_clk_oe  <= can_retry;
            inh_cnt     <= '0;
            if (can_retry) begin
               state <= ST_INHIBIT;
            end else begin
               state          <= ST_DONE;
               tx.done        <= 1'b1;
               tx.err_timeout <= 1'b1;
            end
         end else begin
            case (state)
               ST_IDLE: begin
                  if (tx.tx_valid) begin
                     byte_q      <= tx.tx_data;
                     par_q       <= odd_parity(tx.tx_data);
                     inh_cnt     <= '0;
                     ps2_clk_oe  <= 1'b1;
                     tx.tx_ready <= 1'b0;
                     tx.busy     <= 1'b1;
                     state       <= ST_INHIBIT;
                  end
               end

               ST_INHIBIT: begin
                  inh_cnt <= inh_cnt + 1'b1;
                  // Start bit goes down while clock is still held, so the
                  // device sees data low the moment clock is released.
                  if (inh_cnt == IW'(INHIBIT_CYCLES - 2)) ps2_data_oe <= 1'b1;
                  if (inh_cnt == IW'(INHIBIT_CYCLES - 1)) begin
                     ps2_clk_oe <= 1'b0;
                     state      <= ST_RTS;
                  end
               end

               ST_RTS: begin
                  if (fall) begin
                     ps2_data_oe <= ~byte_q[0];
                     bit_idx     <= 4'd1;
                     state       <= ST_DATA;
                  end
               end

               ST_DATA: begin
                  if (fall) begin
                     if (bit_idx == 4'(DATA_BITS)) begin
                        ps2_data_oe <= ~par_q;
                        state       <= ST_PARITY;
                     end else begin
                        ps2_data_oe <= ~byte_q[bit_idx[2:0]];
                        bit_idx     <= bit_idx + 1'b1;
                     end
                  end
               end

               ST_PARITY: begin
                  if (fall) begin
                     ps2_data_oe <= 1'b0;   // stop bit: released line reads 1
                     state       <= ST_ACK;
                  end
               end

               ST_ACK: begin
                  if (fall) begin
                     ack_r <= ~data_f;      // device pulls data low to ACK
                     state <= ST_LINEWAIT;
                  end
               end

               ST_LINEWAIT: begin
                  if (line_idle) begin
                     if (!ack_r && can_retry) begin
                        ps2_clk_oe <= 1'b1;
                        inh_cnt    <= '0;
                        state      <= ST_INHIBIT;
                     end else begin
                        tx.done     <= 1'b1;
                        tx.ack_ok   <= ack_r;
                        tx.err_nack <= ~ack_r;
                        state       <= ST_DONE;
                     end
                  end
               end

               ST_DONE: begin
                  tx.tx_ready <= 1'b1;
                  tx.busy     <= 1'b0;
                  state       <= ST_IDLE;
               end

               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule
